// File: rtl/htd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package htd_pkg;
    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Decimal digits required to show 2^width-1; lets the top drop the overflow path when it cannot fire.
    function automatic int digits_needed(input int width);
        logic [63:0] v;
        int n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        for (int i = 0; i < 20; i++) begin
            if (v >= 64'd10) begin
                v = v / 64'd10;
                n++;
            end
        end
        return n;
    endfunction
endpackage

// File: rtl/htd_bcd_seq_if.sv
// Data strobe and result/status bundle between a binary source and the BCD converter.
interface htd_bcd_seq_if
    import htd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BCD_DIGITS = 3
);
    logic [DATA_WIDTH-1:0]       iv_data;
    logic                        i_data_wr;
    logic                        o_busy;
    logic [BCD_W*BCD_DIGITS-1:0] ov_bcd;
    logic                        o_sign;
    logic                        o_overflow;
    logic                        o_data_wr;
    logic                        o_drop;

    modport master (
        output iv_data, i_data_wr,
        input  o_busy, ov_bcd, o_sign, o_overflow, o_data_wr, o_drop
    );

    modport slave (
        input  iv_data, i_data_wr,
        output o_busy, ov_bcd, o_sign, o_overflow, o_data_wr, o_drop
    );
endinterface

// File: rtl/htd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift left taking in one binary bit.
module htd_dabble_step
    import htd_pkg::*;
#(
    parameter int BCD_DIGITS = 3
) (
    input  logic [BCD_W*BCD_DIGITS-1:0] i_acc,
    input  logic                        i_bit,
    output logic [BCD_W*BCD_DIGITS-1:0] o_acc,
    output logic                        o_carry
);
    localparam int ACC_W = BCD_W * BCD_DIGITS;

    logic [ACC_W-1:0] w_adj;

    always_comb begin
        w_adj = i_acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (i_acc[d*BCD_W +: BCD_W] >= 4'd5) begin
                w_adj[d*BCD_W +: BCD_W] = i_acc[d*BCD_W +: BCD_W] + 4'd3;
            end
        end
    end

    assign o_carry = w_adj[ACC_W-1];
    assign o_acc   = {w_adj[ACC_W-2:0], i_bit};
endmodule

// File: rtl/htd_bcd_seq.sv
// Sequential binary-to-BCD converter, one magnitude bit per clock, optional two's-complement input.
//   state | meaning
//   IDLE  | waiting for i_data_wr, result outputs hold last value
//   SHIFT | DATA_WIDTH dabble steps, MSB first
//   DONE  | publish result, pulse o_data_wr
module htd_bcd_seq
    import htd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BCD_DIGITS = 3,
    parameter int SIGNED     = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    htd_bcd_seq_if.slave bus
);
    localparam int                ACC_W        = BCD_W * BCD_DIGITS;
    localparam int                CNT_W        = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT     = CNT_W'(DATA_WIDTH - 1);
    localparam bit                OVF_POSSIBLE = BCD_DIGITS < digits_needed(DATA_WIDTH);
    localparam logic [ACC_W-1:0]  ALL_NINES    = {BCD_DIGITS{4'h9}};

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_mag;
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_ovf;
    logic                    r_sign;
    logic [ACC_W-1:0]        r_bcd;
    logic                    r_sign_out;
    logic                    r_ovf_out;
    logic                    r_data_wr;
    logic                    r_drop;
    logic                    w_neg;
    logic [DATA_WIDTH-1:0]   w_mag;
    logic [ACC_W-1:0]        w_acc_next;
    logic                    w_carry;

    // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude.
    assign w_neg = (SIGNED != 0) && bus.iv_data[DATA_WIDTH-1];
    assign w_mag = w_neg ? (~bus.iv_data + DATA_WIDTH'(1)) : bus.iv_data;

    htd_dabble_step #(.BCD_DIGITS(BCD_DIGITS)) u_step (
        .i_acc   (r_acc),
        .i_bit   (r_mag[DATA_WIDTH-1]),
        .o_acc   (w_acc_next),
        .o_carry (w_carry)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.i_data_wr) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == LAST_BIT) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mag      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_sign     <= 1'b0;
            r_bcd      <= '0;
            r_sign_out <= 1'b0;
            r_ovf_out  <= 1'b0;
            r_data_wr  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_data_wr <= 1'b0;
            r_drop    <= bus.i_data_wr && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (bus.i_data_wr) begin
                        r_mag  <= w_mag;
                        r_sign <= w_neg;
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_mag <= r_mag << 1;
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_carry;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    r_bcd      <= (OVF_POSSIBLE && r_ovf) ? ALL_NINES : r_acc;
                    r_sign_out <= r_sign;
                    r_ovf_out  <= OVF_POSSIBLE && r_ovf;
                    r_data_wr  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy     = (r_state != IDLE);
    assign bus.ov_bcd     = r_bcd;
    assign bus.o_sign     = r_sign_out;
    assign bus.o_overflow = r_ovf_out;
    assign bus.o_data_wr  = r_data_wr;
    assign bus.o_drop     = r_drop;
endmodule

// File: tb/tb_htd_bcd_seq.sv
// Scoreboard bench: default, signed and two-digit converters share clock and reset.
module tb_htd_bcd_seq;
    import htd_pkg::*;

    typedef struct packed {
        logic [11:0] bcd;
        logic        sign;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_drop_a = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    htd_bcd_seq_if #(.DATA_WIDTH(8), .BCD_DIGITS(3)) bus_a ();
    htd_bcd_seq_if #(.DATA_WIDTH(8), .BCD_DIGITS(3)) bus_b ();
    htd_bcd_seq_if #(.DATA_WIDTH(8), .BCD_DIGITS(2)) bus_c ();

    htd_bcd_seq #(.DATA_WIDTH(8), .BCD_DIGITS(3), .SIGNED(0)) u_dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
    htd_bcd_seq #(.DATA_WIDTH(8), .BCD_DIGITS(3), .SIGNED(1)) u_dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));
    htd_bcd_seq #(.DATA_WIDTH(8), .BCD_DIGITS(2), .SIGNED(0)) u_dut_c (.i_clk(clk), .i_rst(rst), .bus(bus_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(input logic [11:0] bcd, input logic sign, input logic ovf);
        exp_t e;
        e.bcd  = bcd;
        e.sign = sign;
        e.ovf  = ovf;
        return e;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function automatic void pop_check(input string name, inout exp_t q[$], input exp_t act);
        exp_t e;
        if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: unexpected result %h, expected none", name, act);
        end else begin
            e = q.pop_front();
            check(name, 32'(act), 32'(e));
        end
    endfunction

    always @(negedge clk) begin
        if (bus_a.o_drop) n_drop_a++;
        if (bus_a.o_data_wr) pop_check("res_a", q_a, mk(bus_a.ov_bcd, bus_a.o_sign, bus_a.o_overflow));
    end

    always @(negedge clk) begin
        if (bus_b.o_data_wr) pop_check("res_signed", q_b, mk(bus_b.ov_bcd, bus_b.o_sign, bus_b.o_overflow));
    end

    always @(negedge clk) begin
        if (bus_c.o_data_wr) pop_check("res_2dig", q_c, mk({4'h0, bus_c.ov_bcd}, bus_c.o_sign, bus_c.o_overflow));
    end

    function automatic logic busy_of(input int which);
        case (which)
            0:       return bus_a.o_busy;
            1:       return bus_b.o_busy;
            default: return bus_c.o_busy;
        endcase
    endfunction

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        while (busy_of(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: dut %0d still busy after %0d cycles, expected idle", which, n);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input exp_t e);
        wait_idle(which);
        case (which)
            0: begin bus_a.iv_data = d; bus_a.i_data_wr = 1'b1; q_a.push_back(e); end
            1: begin bus_b.iv_data = d; bus_b.i_data_wr = 1'b1; q_b.push_back(e); end
            default: begin bus_c.iv_data = d; bus_c.i_data_wr = 1'b1; q_c.push_back(e); end
        endcase
        @(negedge clk);
        bus_a.i_data_wr = 1'b0;
        bus_b.i_data_wr = 1'b0;
        bus_c.i_data_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time %0t, expected earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int drops0;
        int first_wr;
        int busy_cnt;

        rst = 1'b1;
        bus_a.iv_data = '0; bus_a.i_data_wr = 1'b0;
        bus_b.iv_data = '0; bus_b.i_data_wr = 1'b0;
        bus_c.iv_data = '0; bus_c.i_data_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_a", {bus_a.ov_bcd, bus_a.o_sign, bus_a.o_overflow, bus_a.o_data_wr, bus_a.o_busy, bus_a.o_drop}, 32'd0);
        check("reset_b", {bus_b.ov_bcd, bus_b.o_sign, bus_b.o_overflow, bus_b.o_data_wr, bus_b.o_busy, bus_b.o_drop}, 32'd0);
        check("reset_c", {bus_c.ov_bcd, bus_c.o_sign, bus_c.o_overflow, bus_c.o_data_wr, bus_c.o_busy, bus_c.o_drop}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 255: result strobe 9 edges after accept, busy for exactly those 9 cycles
        q_a.push_back(mk(12'h255, 1'b0, 1'b0));
        bus_a.iv_data = 8'd255;
        bus_a.i_data_wr = 1'b1;
        first_wr = 0;
        busy_cnt = 0;
        for (int s = 1; s <= 20; s++) begin
            @(negedge clk);
            bus_a.i_data_wr = 1'b0;
            if (bus_a.o_busy) busy_cnt++;
            if (bus_a.o_data_wr && first_wr == 0) first_wr = s;
        end
        check("latency_255", 32'(first_wr - 1), 32'd9);
        check("busy_cycles_255", 32'(busy_cnt), 32'd9);

        drops0 = n_drop_a;
        send(0, 8'd0,   mk(12'h000, 1'b0, 1'b0));
        send(0, 8'd1,   mk(12'h001, 1'b0, 1'b0));
        send(0, 8'd9,   mk(12'h009, 1'b0, 1'b0));
        send(0, 8'd10,  mk(12'h010, 1'b0, 1'b0));
        send(0, 8'd99,  mk(12'h099, 1'b0, 1'b0));
        send(0, 8'd100, mk(12'h100, 1'b0, 1'b0));
        wait_idle(0);
        repeat (2) @(negedge clk);
        check("no_drop_b2b", 32'(n_drop_a - drops0), 32'd0);

        send(1, 8'h80, mk(12'h128, 1'b1, 1'b0));
        send(1, 8'hFF, mk(12'h001, 1'b1, 1'b0));
        send(1, 8'h7F, mk(12'h127, 1'b0, 1'b0));
        send(1, 8'h00, mk(12'h000, 1'b0, 1'b0));
        send(1, 8'h9C, mk(12'h100, 1'b1, 1'b0));

        send(2, 8'd123, mk(12'h099, 1'b0, 1'b1));
        send(2, 8'd99,  mk(12'h099, 1'b0, 1'b0));
        send(2, 8'd5,   mk(12'h005, 1'b0, 1'b0));
        send(2, 8'd255, mk(12'h099, 1'b0, 1'b1));
        wait_idle(1);
        wait_idle(2);

        // six strobes back to back: first accepted, the next five dropped
        wait_idle(0);
        drops0 = n_drop_a;
        q_a.push_back(mk(12'h001, 1'b0, 1'b0));
        bus_a.iv_data = 8'd1;
        bus_a.i_data_wr = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            @(negedge clk);
            bus_a.iv_data = 8'(k);
        end
        @(negedge clk);
        bus_a.i_data_wr = 1'b0;
        wait_idle(0);
        repeat (2) @(negedge clk);
        check("drop_count", 32'(n_drop_a - drops0), 32'd5);

        // reset four cycles into converting 200; aborted word must never appear
        bus_a.iv_data = 8'd200;
        bus_a.i_data_wr = 1'b1;
        @(negedge clk);
        bus_a.i_data_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_during_conv", {bus_a.ov_bcd, bus_a.o_busy}, {12'h001, 1'b1});
        rst = 1'b1;
        #1;
        check("reset_midconv", {bus_a.ov_bcd, bus_a.o_sign, bus_a.o_overflow, bus_a.o_data_wr, bus_a.o_busy, bus_a.o_drop}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'd200, mk(12'h200, 1'b0, 1'b0));
        wait_idle(0);

        repeat (5) @(negedge clk);
        check("queue_a_empty", 32'(q_a.size()), 32'd0);
        check("queue_b_empty", 32'(q_b.size()), 32'd0);
        check("queue_c_empty", 32'(q_c.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/htd_bcd_seq.md
Name: htd_bcd_seq

Overview:
Parametrised sequential binary-to-BCD (hex-to-decimal) converter using the shift-and-add-3 (double dabble) method.
- Generalises the 8-bit converter in three ways: configurable input width and digit count, optional two's-complement input, and explicit busy/drop/overflow status.
- Sits between a binary data source (counters, ADC words) and decimal display or UART formatting logic.
- Uses the team's strobe convention: i_data_wr in, o_data_wr out.

Parameters:
- DATA_WIDTH, 8: input word width in bits, 2..32.
- BCD_DIGITS, 3: number of BCD output digits, 1..10. May be set below the digit count needed for the full input range.
- SIGNED, 0: 0 = input is unsigned; 1 = input is two's complement, converted as sign plus magnitude.

Ports:
- i_clk, in, 1: single clock, rising edge.
- i_rst, in, 1: asynchronous, active-high reset.
- iv_data, in, DATA_WIDTH: binary input word.
- i_data_wr, in, 1: input strobe. Accepted only when o_busy=0.
- o_busy, out, 1: converter occupied. High from the cycle after accept until the cycle o_data_wr is asserted.
- ov_bcd, out, 4*BCD_DIGITS: packed BCD result. Digit 0 (units) is in bits [3:0].
- o_sign, out, 1: 1 = negative result. Always 0 when SIGNED=0.
- o_overflow, out, 1: magnitude exceeded 10^BCD_DIGITS-1. Valid with o_data_wr.
- o_data_wr, out, 1: one-cycle result strobe.
- o_drop, out, 1: one-cycle pulse when i_data_wr arrives while o_busy=1.

Behaviour:
- Clock and reset (already decided): one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset: all outputs 0 (ov_bcd=0, o_sign=0, o_overflow=0, o_data_wr=0, o_busy=0, o_drop=0), state=IDLE, internal registers cleared.
- States: IDLE, SHIFT, DONE.
- IDLE, i_data_wr=1 at edge E:
  - latch magnitude into the shift register: iv_data, or |iv_data| when SIGNED=1 and MSB=1;
  - latch the sign; clear the BCD accumulator, overflow flag and bit counter;
  - go to SHIFT.
- SHIFT, one bit per clock, MSB first:
  - add 3 to every accumulator digit >=5;
  - shift left by one, bringing in the next magnitude bit;
  - any 1 shifted out of the top digit sets the sticky overflow flag;
  - after DATA_WIDTH shifts (edge E+DATA_WIDTH) go to DONE.
- DONE, edge E+DATA_WIDTH+1:
  - register ov_bcd, o_sign and o_overflow; pulse o_data_wr=1 for one cycle;
  - go to IDLE; o_busy falls on the same edge.
- Latency: o_data_wr is high in the cycle after edge E+DATA_WIDTH+1. Earliest next accept is edge E+DATA_WIDTH+2, so peak throughput is one word per DATA_WIDTH+2 cycles.
- Output hold: ov_bcd, o_sign and o_overflow hold the last result until the next o_data_wr. They do not change during conversion.
- Overflow: when the flag is set, ov_bcd saturates to all 9s and o_overflow=1.
- Signed most-negative input: -2^(DATA_WIDTH-1) converts with a DATA_WIDTH-bit unsigned magnitude; no extra bit is needed.
- Zero: ov_bcd=0, o_sign=0; no negative zero is possible.
- i_data_wr while busy (SHIFT or DONE): input ignored, o_drop=1 for one cycle, current conversion unaffected.
- i_data_wr and o_data_wr in the same cycle: state is IDLE at that point, so the input is accepted normally.
- Reset asserted mid-conversion: immediate return to reset values; no o_data_wr for the aborted word.

Decomposition:
- Package htd_pkg:
  - state enum encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - constant function digits_needed(width), used for elaboration-time range checks;
  - BCD nibble width constant = 4.
- Sub-module htd_dabble_step:
  - combinational: for BCD_DIGITS digits plus one input bit, produces the add-3-corrected, shifted accumulator and the carry-out bit;
  - instantiated once, used each SHIFT cycle.

Test Plan:
- Unsigned 255, defaults → ov_bcd=12'h255, o_overflow=0, o_data_wr exactly 9 cycles after the accept edge; o_busy high for those 9 cycles.
- Inputs 0, 1, 9, 10, 99, 100 back-to-back, each re-driven as soon as o_busy falls → ov_bcd 000/001/009/010/099/100 in order, no o_drop.
- SIGNED=1: -128 → o_sign=1, ov_bcd=12'h128; -1 → o_sign=1, 12'h001; 127 → o_sign=0, 12'h127.
- BCD_DIGITS=2: 123 → o_overflow=1, ov_bcd=8'h99; 99 → o_overflow=0, 8'h99.
- i_data_wr=1 for 6 consecutive cycles with data 1..6 → only 1 is converted (12'h001); o_drop pulses on the 5 following cycles.
- i_rst asserted 4 cycles into a conversion of 200 → all outputs 0 at once, no o_data_wr; after release, 200 → 12'h200.
